// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU encodings, field
// positions, control bundle and halt FSM states.
package id_stage_pkg;

  localparam int DW   = 8;
  localparam int NREG = 4;
  localparam int IW   = 16;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RS1_HI = 11;
  localparam int RS1_LO = 10;
  localparam int RS2_HI = 9;
  localparam int RS2_LO = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BZ   = 4'hA;
  localparam logic [3:0] OP_BN   = 4'hB;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_PASS = 3'd4
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    r2_to_rd;
    logic    reg_write;
    logic    jump;
    logic    branch_zero;
    logic    branch_neg;
    logic    halt;
    logic    use_rs1;
    logic    use_rs2;
  } ctrl_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } halt_state_e;

  function automatic logic src_hit(
    input ctrl_t      c,
    input logic [1:0] rd,
    input logic [1:0] rs1,
    input logic [1:0] rs2
  );
    return (c.use_rs1 && (rd == rs1)) ||
           (c.use_rs2 && (rd == rs2));
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Pure combinational opcode decoder: control bundle plus source-usage flags.
// Unlisted opcodes decode as NOP.
module id_decoder
  import id_stage_pkg::*;
(
  input  logic [3:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    ctrl_o.alu_op = ALU_ADD;
    unique case (1'b1)
      (opcode_i == OP_ADD): begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.use_rs1   = 1'b1;
        ctrl_o.use_rs2   = 1'b1;
      end
      (opcode_i == OP_SUB): begin
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.use_rs1   = 1'b1;
        ctrl_o.use_rs2   = 1'b1;
      end
      (opcode_i == OP_AND): begin
        ctrl_o.alu_op    = ALU_AND;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.use_rs1   = 1'b1;
        ctrl_o.use_rs2   = 1'b1;
      end
      (opcode_i == OP_OR): begin
        ctrl_o.alu_op    = ALU_OR;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.use_rs1   = 1'b1;
        ctrl_o.use_rs2   = 1'b1;
      end
      (opcode_i == OP_ADDI): begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.use_rs1   = 1'b1;
      end
      // Load address is rs1 + imm; rd shares the rs1 field.
      (opcode_i == OP_LD): begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.use_rs1    = 1'b1;
      end
      (opcode_i == OP_ST): begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.use_rs1   = 1'b1;
        ctrl_o.use_rs2   = 1'b1;
      end
      (opcode_i == OP_MOV): begin
        ctrl_o.alu_op    = ALU_PASS;
        ctrl_o.r2_to_rd  = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.use_rs2   = 1'b1;
      end
      (opcode_i == OP_JMP): begin
        ctrl_o.jump = 1'b1;
      end
      (opcode_i == OP_BZ): begin
        ctrl_o.alu_op      = ALU_PASS;
        ctrl_o.branch_zero = 1'b1;
        ctrl_o.use_rs1     = 1'b1;
      end
      (opcode_i == OP_BN): begin
        ctrl_o.alu_op     = ALU_PASS;
        ctrl_o.branch_neg = 1'b1;
        ctrl_o.use_rs1    = 1'b1;
      end
      (opcode_i == OP_HLT): begin
        ctrl_o.halt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: regfile, load-use/WB hazard stall, redirect flush, halt FSM.
// Define WB_BYPASS_EN to forward same-cycle WB writes to regfile reads.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int NREG_P = NREG,
  parameter int DW_P   = DW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IW-1:0]   IF_ID_instr,
  input  logic [DW_P-1:0] IF_ID_PC_plus_1,
  input  logic            IF_ID_valid,
  input  logic            EX_mem_read,
  input  logic [1:0]      EX_rd,
  input  logic            EX_redirect,
  input  logic            WB_reg_write,
  input  logic [1:0]      WB_rd,
  input  logic [DW_P-1:0] WB_data,
  output logic [DW_P-1:0] ID_PC_plus_1,
  output logic [DW_P-1:0] ID_reg_data_1,
  output logic [DW_P-1:0] ID_reg_data_2,
  output logic [DW_P-1:0] ID_imm,
  output logic [1:0]      ID_rd,
  output logic [2:0]      ID_alu_op,
  output logic            ID_alu_src,
  output logic            ID_mem_read,
  output logic            ID_mem_write,
  output logic            ID_mem_to_reg,
  output logic            ID_r2_to_rd,
  output logic            ID_reg_write,
  output logic            ID_jump,
  output logic            ID_branch_zero,
  output logic            ID_branch_neg,
  output logic            ID_halt,
  output logic            stall,
  output logic            halted
);

  logic [3:0]      opcode;
  logic [1:0]      rs1;
  logic [1:0]      rs2;
  ctrl_t           ctrl;
  logic [DW_P-1:0] rf_q [NREG_P];
  logic [DW_P-1:0] rd1;
  logic [DW_P-1:0] rd2;
  logic            lu_hz;
  logic            wb_hz;
  logic            bubble;
  halt_state_e     state_q;
  halt_state_e     state_d;

  assign opcode = IF_ID_instr[OPC_HI:OPC_LO];
  assign rs1    = IF_ID_instr[RS1_HI:RS1_LO];
  assign rs2    = IF_ID_instr[RS2_HI:RS2_LO];

  id_decoder u_dec (
    .opcode_i (opcode),
    .ctrl_o   (ctrl)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG_P; i++) rf_q[i] <= '0;
    end else if (WB_reg_write) begin
      rf_q[WB_rd] <= WB_data;
    end
  end

`ifdef WB_BYPASS_EN
  assign rd1 = (WB_reg_write && (WB_rd == rs1)) ? WB_data : rf_q[rs1];
  assign rd2 = (WB_reg_write && (WB_rd == rs2)) ? WB_data : rf_q[rs2];
  assign wb_hz = 1'b0;
`else
  assign rd1 = rf_q[rs1];
  assign rd2 = rf_q[rs2];
  // Without forwarding, wait one cycle for the write to land.
  assign wb_hz = WB_reg_write && src_hit(ctrl, WB_rd, rs1, rs2);
`endif

  assign lu_hz = EX_mem_read && src_hit(ctrl, EX_rd, rs1, rs2);

  assign halted = (state_q == ST_HALTED);

  assign stall = reset &&
                 (halted ||
                  (IF_ID_valid && !EX_redirect && (lu_hz || wb_hz)));

  assign bubble = !reset || !IF_ID_valid || stall ||
                  EX_redirect || halted;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (!bubble && ctrl.halt) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    ID_PC_plus_1   = '0;
    ID_reg_data_1  = '0;
    ID_reg_data_2  = '0;
    ID_imm         = '0;
    ID_rd          = '0;
    ID_alu_op      = '0;
    ID_alu_src     = 1'b0;
    ID_mem_read    = 1'b0;
    ID_mem_write   = 1'b0;
    ID_mem_to_reg  = 1'b0;
    ID_r2_to_rd    = 1'b0;
    ID_reg_write   = 1'b0;
    ID_jump        = 1'b0;
    ID_branch_zero = 1'b0;
    ID_branch_neg  = 1'b0;
    ID_halt        = 1'b0;
    if (!bubble) begin
      ID_PC_plus_1   = IF_ID_PC_plus_1;
      ID_reg_data_1  = rd1;
      ID_reg_data_2  = rd2;
      ID_imm         = IF_ID_instr[IMM_HI:IMM_LO];
      ID_rd          = rs1;
      ID_alu_op      = ctrl.alu_op;
      ID_alu_src     = ctrl.alu_src;
      ID_mem_read    = ctrl.mem_read;
      ID_mem_write   = ctrl.mem_write;
      ID_mem_to_reg  = ctrl.mem_to_reg;
      ID_r2_to_rd    = ctrl.r2_to_rd;
      ID_reg_write   = ctrl.reg_write;
      ID_jump        = ctrl.jump;
      ID_branch_zero = ctrl.branch_zero;
      ID_branch_neg  = ctrl.branch_neg;
      ID_halt        = ctrl.halt;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed vectors push expected bundles,
// a negedge monitor pops and compares.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] IF_ID_instr = '0;
  logic [7:0]  IF_ID_PC_plus_1 = '0;
  logic        IF_ID_valid = 1'b0;
  logic        EX_mem_read = 1'b0;
  logic [1:0]  EX_rd = '0;
  logic        EX_redirect = 1'b0;
  logic        WB_reg_write = 1'b0;
  logic [1:0]  WB_rd = '0;
  logic [7:0]  WB_data = '0;
  logic [7:0]  ID_PC_plus_1, ID_reg_data_1, ID_reg_data_2, ID_imm;
  logic [1:0]  ID_rd;
  logic [2:0]  ID_alu_op;
  logic        ID_alu_src, ID_mem_read, ID_mem_write, ID_mem_to_reg;
  logic        ID_r2_to_rd, ID_reg_write, ID_jump, ID_branch_zero;
  logic        ID_branch_neg, ID_halt, stall, halted;

  int checks = 0;
  int failures = 0;

  logic [48:0] exp_q [$];
  string       nm_q [$];
  logic [48:0] obs;

  localparam logic [2:0] A_ADD  = 3'd0;
  localparam logic [2:0] A_SUB  = 3'd1;
  localparam logic [2:0] A_OR   = 3'd3;
  localparam logic [2:0] A_PASS = 3'd4;

  // {alu_src,mem_read,mem_write,mem_to_reg,r2_to_rd,reg_write,jump,bz,bn,halt}
  localparam logic [9:0] C_NONE = 10'b00000_00000;
  localparam logic [9:0] C_RW   = 10'b00000_10000;
  localparam logic [9:0] C_ADDI = 10'b10000_10000;
  localparam logic [9:0] C_LD   = 10'b11010_10000;
  localparam logic [9:0] C_ST   = 10'b10100_00000;
  localparam logic [9:0] C_MOV  = 10'b00001_10000;
  localparam logic [9:0] C_JMP  = 10'b00000_01000;
  localparam logic [9:0] C_BZ   = 10'b00000_00100;
  localparam logic [9:0] C_HLT  = 10'b00000_00001;

  id_stage dut (
    .clk            (clk),
    .reset          (reset),
    .IF_ID_instr    (IF_ID_instr),
    .IF_ID_PC_plus_1(IF_ID_PC_plus_1),
    .IF_ID_valid    (IF_ID_valid),
    .EX_mem_read    (EX_mem_read),
    .EX_rd          (EX_rd),
    .EX_redirect    (EX_redirect),
    .WB_reg_write   (WB_reg_write),
    .WB_rd          (WB_rd),
    .WB_data        (WB_data),
    .ID_PC_plus_1   (ID_PC_plus_1),
    .ID_reg_data_1  (ID_reg_data_1),
    .ID_reg_data_2  (ID_reg_data_2),
    .ID_imm         (ID_imm),
    .ID_rd          (ID_rd),
    .ID_alu_op      (ID_alu_op),
    .ID_alu_src     (ID_alu_src),
    .ID_mem_read    (ID_mem_read),
    .ID_mem_write   (ID_mem_write),
    .ID_mem_to_reg  (ID_mem_to_reg),
    .ID_r2_to_rd    (ID_r2_to_rd),
    .ID_reg_write   (ID_reg_write),
    .ID_jump        (ID_jump),
    .ID_branch_zero (ID_branch_zero),
    .ID_branch_neg  (ID_branch_neg),
    .ID_halt        (ID_halt),
    .stall          (stall),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  assign obs = {ID_PC_plus_1, ID_reg_data_1, ID_reg_data_2, ID_imm,
                ID_rd, ID_alu_op,
                ID_alu_src, ID_mem_read, ID_mem_write, ID_mem_to_reg,
                ID_r2_to_rd, ID_reg_write, ID_jump, ID_branch_zero,
                ID_branch_neg, ID_halt, stall, halted};

  function automatic logic [48:0] E(
    input logic [7:0] pc, d1, d2, imm,
    input logic [1:0] rd,
    input logic [2:0] op,
    input logic [9:0] c,
    input logic       st, hl
  );
    return {pc, d1, d2, imm, rd, op, c, st, hl};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [48:0] e;
      string       n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", n, obs, e);
      end
    end
  end

  task automatic step(
    input string       nm,
    input logic [15:0] ins,
    input logic [7:0]  pc,
    input logic        v,
    input logic        exmr,
    input logic [1:0]  exrd,
    input logic        redir,
    input logic        wbw,
    input logic [1:0]  wbrd,
    input logic [7:0]  wbd,
    input logic [48:0] e
  );
    IF_ID_instr     = ins;
    IF_ID_PC_plus_1 = pc;
    IF_ID_valid     = v;
    EX_mem_read     = exmr;
    EX_rd           = exrd;
    EX_redirect     = redir;
    WB_reg_write    = wbw;
    WB_rd           = wbrd;
    WB_data         = wbd;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [48:0] BUB, STL, HLD;
    BUB = E(0, 0, 0, 0, 0, 0, C_NONE, 0, 0);
    STL = E(0, 0, 0, 0, 0, 0, C_NONE, 1, 0);
    HLD = E(0, 0, 0, 0, 0, 0, C_NONE, 1, 1);
    @(posedge clk);
    #1;
    step("reset", 16'h1600, 8'h01, 1, 0, 0, 0, 0, 0, 0, BUB);
    reset = 1'b1;
    step("nop", 16'h0000, 8'h01, 1, 0, 0, 0, 0, 0, 0,
         E(8'h01, 0, 0, 0, 0, A_ADD, C_NONE, 0, 0));
`ifdef WB_BYPASS_EN
    step("wb_r2_add", 16'h1600, 8'h02, 1, 0, 0, 0, 1, 2, 8'h5A,
         E(8'h02, 0, 8'h5A, 0, 1, A_ADD, C_RW, 0, 0));
`else
    step("wb_r2_add", 16'h1600, 8'h02, 1, 0, 0, 0, 1, 2, 8'h5A, STL);
`endif
    step("add_r1r2", 16'h1600, 8'h02, 1, 0, 0, 0, 0, 0, 0,
         E(8'h02, 0, 8'h5A, 0, 1, A_ADD, C_RW, 0, 0));
    step("wb_r3", 16'h0000, 8'h03, 0, 0, 0, 0, 1, 3, 8'h33, BUB);
    step("wb_r1", 16'h0000, 8'h04, 0, 0, 0, 0, 1, 1, 8'h11, BUB);
    step("ld_use", 16'h1700, 8'h07, 1, 1, 1, 0, 0, 0, 0, STL);
    step("add_after_ld", 16'h1700, 8'h07, 1, 0, 0, 0, 0, 0, 0,
         E(8'h07, 8'h11, 8'h33, 0, 1, A_ADD, C_RW, 0, 0));
    step("ld_jmp", 16'h9042, 8'h08, 1, 1, 1, 0, 0, 0, 0,
         E(8'h08, 0, 0, 8'h42, 0, A_ADD, C_JMP, 0, 0));
    step("redirect", 16'h1700, 8'h09, 1, 1, 1, 1, 0, 0, 0, BUB);
    step("addi", 16'h587F, 8'h0A, 1, 0, 0, 0, 0, 0, 0,
         E(8'h0A, 8'h5A, 0, 8'h7F, 2, A_ADD, C_ADDI, 0, 0));
    step("ld", 16'h6C05, 8'h0B, 1, 0, 0, 0, 0, 0, 0,
         E(8'h0B, 8'h33, 0, 8'h05, 3, A_ADD, C_LD, 0, 0));
    step("st", 16'h7610, 8'h0C, 1, 0, 0, 0, 0, 0, 0,
         E(8'h0C, 8'h11, 8'h5A, 8'h10, 1, A_ADD, C_ST, 0, 0));
    step("mov", 16'h8300, 8'h0D, 1, 0, 0, 0, 0, 0, 0,
         E(8'h0D, 0, 8'h33, 0, 0, A_PASS, C_MOV, 0, 0));
    step("bz", 16'hA4F0, 8'h0E, 1, 0, 0, 0, 0, 0, 0,
         E(8'h0E, 8'h11, 0, 8'hF0, 1, A_PASS, C_BZ, 0, 0));
    step("sub", 16'h2900, 8'h0F, 1, 0, 0, 0, 0, 0, 0,
         E(8'h0F, 8'h5A, 8'h11, 0, 2, A_SUB, C_RW, 0, 0));
    step("undef_op", 16'hC7AA, 8'h10, 1, 0, 0, 0, 0, 0, 0,
         E(8'h10, 8'h11, 8'h33, 8'hAA, 1, A_ADD, C_NONE, 0, 0));
`ifdef WB_BYPASS_EN
    step("wb_haz_or", 16'h4700, 8'h11, 1, 0, 0, 0, 1, 3, 8'h44,
         E(8'h11, 8'h11, 8'h44, 0, 1, A_OR, C_RW, 0, 0));
`else
    step("wb_haz_or", 16'h4700, 8'h11, 1, 0, 0, 0, 1, 3, 8'h44, STL);
`endif
    step("or", 16'h4700, 8'h11, 1, 0, 0, 0, 0, 0, 0,
         E(8'h11, 8'h11, 8'h44, 0, 1, A_OR, C_RW, 0, 0));
    step("hlt_redir", 16'hF000, 8'h12, 1, 0, 0, 1, 0, 0, 0, BUB);
    step("hlt_pulse", 16'hF000, 8'h13, 1, 1, 0, 0, 0, 0, 0,
         E(8'h13, 0, 0, 0, 0, A_ADD, C_HLT, 0, 0));
    step("halted", 16'h1600, 8'h14, 1, 0, 0, 0, 0, 0, 0, HLD);
    step("halted_wb", 16'h1600, 8'h15, 1, 0, 0, 0, 1, 0, 8'h77, HLD);
    step("halted_redir", 16'h1600, 8'h16, 1, 0, 0, 1, 0, 0, 0, HLD);
    reset = 1'b0;
    step("rst_halted", 16'h1600, 8'h17, 1, 0, 0, 0, 0, 0, 0, BUB);
    reset = 1'b1;
    step("post_rst", 16'h1600, 8'h20, 1, 0, 0, 0, 0, 0, 0,
         E(8'h20, 0, 0, 0, 1, A_ADD, C_RW, 0, 0));
    step("wb_r1_b", 16'h0000, 8'h21, 0, 0, 0, 0, 1, 1, 8'h99, BUB);
    step("ld_stall2", 16'h1700, 8'h22, 1, 1, 1, 0, 0, 0, 0, STL);
    reset = 1'b0;
    step("rst_mid_stall", 16'h1700, 8'h22, 1, 1, 1, 0, 0, 0, 0, BUB);
    reset = 1'b1;
    step("rd_after_rst", 16'h1700, 8'h23, 1, 0, 0, 0, 0, 0, 0,
         E(8'h23, 0, 0, 0, 1, A_ADD, C_RW, 0, 0));
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
